// File: rtl/pwm_seq_pkg.sv
// Shared types and register map for the PWM segment queue.
package pwm_seq_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REP_W  = 16;

  typedef struct packed {
    logic [DATA_W-1:0] on;
    logic [DATA_W-1:0] off;
    logic [REP_W-1:0]  rpt;
  } seg_entry_t;

  localparam logic [2:0] ADDR_ON     = 3'd0;
  localparam logic [2:0] ADDR_OFF    = 3'd1;
  localparam logic [2:0] ADDR_REPEAT = 3'd2;
  localparam logic [2:0] ADDR_CTRL   = 3'd3;
  localparam logic [2:0] ADDR_ISSUED = 3'd4;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_IRQ_EN  = 1;
  localparam int unsigned CTRL_EMPTY   = 2;
  localparam int unsigned CTRL_OVF     = 3;
  localparam int unsigned CTRL_FLUSH   = 4;
  localparam int unsigned CTRL_LVL_LSB = 5;
  localparam int unsigned CTRL_LVL_W   = 4;

  // A zero repeat still produces one offer.
  function automatic logic [REP_W-1:0] eff_repeat(input logic [REP_W-1:0] r);
    return (r == '0) ? REP_W'(1) : r;
  endfunction

endpackage

// File: rtl/seg_fifo.sv
// Synchronous segment FIFO; push is refused when full, pop when empty, flush wins.
module seg_fifo
  import pwm_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  seg_entry_t             data_i,
  input  logic                   pop_i,
  output seg_entry_t             head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  seg_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == LW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + LW'(1);
        2'b01:   count_d = count_q - LW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pwm_seg_queue.sv
// Segment queue for a PWM stage: Avalon-MM register file in front of a FIFO
// whose head entry is offered max(REPEAT,1) times before it is popped.
module pwm_seg_queue
  import pwm_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              csi_clk,
  input  logic              rsi_reset,
  input  logic              avs_s0_read,
  input  logic              avs_s0_write,
  input  logic [2:0]        avs_s0_address,
  input  logic [DATA_W-1:0] avs_s0_writedata,
  output logic [DATA_W-1:0] avs_s0_readdata,
  output logic              ins_irq_n,
  output logic              aso_seg_valid,
  input  logic              aso_seg_ready,
  output logic [DATA_W-1:0] aso_seg_on,
  output logic [DATA_W-1:0] aso_seg_off,
  output logic              aso_seg_last
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] on_q, on_d, off_q, off_d;
  logic [DATA_W-1:0] issued_q, issued_d, rdata_q, rdata_d;
  logic [REP_W-1:0]  rep_q, rep_d, cnt_q, cnt_d;
  logic              en_q, en_d, irq_en_q, irq_en_d;
  logic              empty_flag_q, empty_flag_d, ovf_flag_q, ovf_flag_d;

  logic              wr_on, wr_off, wr_rep, wr_ctrl, flush;
  logic              hs, pop, push_ok, last_match, empty_set, ovf_set;
  logic              fifo_full, fifo_empty;
  logic [LW-1:0]     level;
  logic [DATA_W-1:0] ctrl_rd;
  seg_entry_t        head, push_data;

  assign wr_on   = avs_s0_write && (avs_s0_address == ADDR_ON);
  assign wr_off  = avs_s0_write && (avs_s0_address == ADDR_OFF);
  assign wr_rep  = avs_s0_write && (avs_s0_address == ADDR_REPEAT);
  assign wr_ctrl = avs_s0_write && (avs_s0_address == ADDR_CTRL);
  assign flush   = wr_ctrl && avs_s0_writedata[CTRL_FLUSH];

  assign push_data.on  = on_q;
  assign push_data.off = off_q;
  assign push_data.rpt = avs_s0_writedata[REP_W-1:0];

  seg_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (csi_clk),
    .rst_i   (rsi_reset),
    .flush_i (flush),
    .push_i  (wr_rep),
    .data_i  (push_data),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  // Streaming side: offer the head, pop it after its final repeat.
  assign aso_seg_valid = en_q && !fifo_empty;
  assign aso_seg_on    = head.on;
  assign aso_seg_off   = head.off;
  assign last_match    = (cnt_q == (eff_repeat(head.rpt) - REP_W'(1)));
  assign aso_seg_last  = aso_seg_valid && last_match;
  assign hs            = aso_seg_valid && aso_seg_ready && !flush;
  assign pop           = hs && last_match;

  // Fullness is the pre-pop state, so a push into a full FIFO drops even if it pops.
  assign push_ok   = wr_rep && !fifo_full;
  assign ovf_set   = wr_rep && fifo_full;
  assign empty_set = pop && (level == LW'(1)) && !push_ok;

  assign ins_irq_n = !(irq_en_q && (empty_flag_q || ovf_flag_q));

  always_comb begin
    ctrl_rd                                 = '0;
    ctrl_rd[CTRL_EN]                        = en_q;
    ctrl_rd[CTRL_IRQ_EN]                    = irq_en_q;
    ctrl_rd[CTRL_EMPTY]                     = empty_flag_q;
    ctrl_rd[CTRL_OVF]                       = ovf_flag_q;
    ctrl_rd[CTRL_LVL_LSB +: CTRL_LVL_W]     = CTRL_LVL_W'(level);
  end

  always_comb begin
    on_d         = on_q;
    off_d        = off_q;
    rep_d        = rep_q;
    en_d         = en_q;
    irq_en_d     = irq_en_q;
    issued_d     = issued_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    if (wr_on)  on_d  = avs_s0_writedata;
    if (wr_off) off_d = avs_s0_writedata;
    if (wr_rep) rep_d = avs_s0_writedata[REP_W-1:0];
    if (wr_ctrl) begin
      en_d     = avs_s0_writedata[CTRL_EN];
      irq_en_d = avs_s0_writedata[CTRL_IRQ_EN];
    end
    // Hardware set beats a same-cycle write-1-to-clear.
    empty_flag_d = empty_set ||
                   (empty_flag_q && !(wr_ctrl && avs_s0_writedata[CTRL_EMPTY]));
    ovf_flag_d   = ovf_set ||
                   (ovf_flag_q && !(wr_ctrl && avs_s0_writedata[CTRL_OVF]));
    if (flush) begin
      cnt_d = '0;
    end else if (hs) begin
      issued_d = issued_q + DATA_W'(1);
      cnt_d    = pop ? '0 : cnt_q + REP_W'(1);
    end
    if (avs_s0_read) begin
      case (avs_s0_address)
        ADDR_ON:     rdata_d = on_q;
        ADDR_OFF:    rdata_d = off_q;
        ADDR_REPEAT: rdata_d = DATA_W'(rep_q);
        ADDR_CTRL:   rdata_d = ctrl_rd;
        ADDR_ISSUED: rdata_d = issued_q;
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      on_q         <= '0;
      off_q        <= '0;
      rep_q        <= '0;
      en_q         <= 1'b0;
      irq_en_q     <= 1'b0;
      empty_flag_q <= 1'b0;
      ovf_flag_q   <= 1'b0;
      issued_q     <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
    end else begin
      on_q         <= on_d;
      off_q        <= off_d;
      rep_q        <= rep_d;
      en_q         <= en_d;
      irq_en_q     <= irq_en_d;
      empty_flag_q <= empty_flag_d;
      ovf_flag_q   <= ovf_flag_d;
      issued_q     <= issued_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
    end
  end

  assign avs_s0_readdata = rdata_q;

endmodule
